irrigation_countdown: RTL

IRRIGATION_COUNTDOWN -- requirements
Module: irrigation_countdown

---
 rtl/irrigation_countdown.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/irrigation_countdown.sv
// MM:SS irrigation countdown timer with BCD digits, a one-second prescaler,
// preset loading with clamping, and an IDLE/RUN/PAUSE state machine.
module irrigation_countdown #(
  parameter int TICKS_PER_SECOND = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       timer_load,
  input  logic       run,
  input  logic [1:0] minutes_d_preset,
  input  logic [3:0] minutes_u_preset,
  input  logic [2:0] seconds_d_preset,
  output logic [1:0] minutes_d,
  output logic [3:0] minutes_u,
  output logic [2:0] seconds_d,
  output logic [3:0] seconds_u,
  output logic       second_tick,
  output logic       expired,
  output logic       active
);

  localparam int PW = (TICKS_PER_SECOND > 2) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [PW-1:0] LP_LAST = PW'(TICKS_PER_SECOND - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_md;
  logic [3:0]    r_mu;
  logic [2:0]    r_sd;
  logic [3:0]    r_su;
  logic          r_tick;
  logic          r_expired;
  logic          r_active;

  state_t        w_state_nxt;
  logic [1:0]    w_md_dec;
  logic [3:0]    w_mu_dec;
  logic [2:0]    w_sd_dec;
  logic [3:0]    w_su_dec;
  logic [3:0]    w_ld_mu;
  logic [2:0]    w_ld_sd;
  logic          w_zero;
  logic          w_dec_zero;
  logic          w_load_zero;
  logic          w_wrap;
  logic          w_go;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  function automatic logic [2:0] clamp_tens(input logic [2:0] v);
    return (v > 3'd5) ? 3'd5 : v;
  endfunction

  assign w_ld_mu     = clamp_bcd(minutes_u_preset);
  assign w_ld_sd     = clamp_tens(seconds_d_preset);
  assign w_load_zero = (minutes_d_preset == 2'd0) && (w_ld_mu == 4'd0) && (w_ld_sd == 3'd0);
  assign w_zero      = ({r_md, r_mu, r_sd, r_su} == 13'd0);
  assign w_dec_zero  = ({w_md_dec, w_mu_dec, w_sd_dec, w_su_dec} == 13'd0);
  assign w_wrap      = (r_presc == LP_LAST);
  // Counting happens in any cycle that leaves the FSM in RUN, so a resume keeps the prescaler phase.
  assign w_go        = run && !w_zero;

  // BCD borrow chain for one-second decrement; only used when the count is nonzero.
  always_comb begin
    w_md_dec = r_md;
    w_mu_dec = r_mu;
    w_sd_dec = r_sd;
    w_su_dec = r_su;
    if (r_su != 4'd0) begin
      w_su_dec = r_su - 4'd1;
    end else begin
      w_su_dec = 4'd9;
      if (r_sd != 3'd0) begin
        w_sd_dec = r_sd - 3'd1;
      end else begin
        w_sd_dec = 3'd5;
        if (r_mu != 4'd0) begin
          w_mu_dec = r_mu - 4'd1;
        end else begin
          w_mu_dec = 4'd9;
          w_md_dec = r_md - 2'd1;
        end
      end
    end
  end

  // Next FSM state; a load keeps the current state unless it loads 00:00.
  always_comb begin
    w_state_nxt = r_state;
    if (timer_load) begin
      w_state_nxt = w_load_zero ? ST_IDLE : r_state;
    end else if (w_zero) begin
      w_state_nxt = ST_IDLE;
    end else if (run) begin
      w_state_nxt = (w_wrap && w_dec_zero) ? ST_IDLE : ST_RUN;
    end else if (r_state == ST_IDLE) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = ST_PAUSE;
    end
  end

  // State, prescaler, digits and pulse outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_active  <= 1'b0;
      r_presc   <= '0;
      r_md      <= 2'd0;
      r_mu      <= 4'd0;
      r_sd      <= 3'd0;
      r_su      <= 4'd0;
      r_tick    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= (w_state_nxt == ST_RUN);
      if (timer_load) begin
        r_md      <= minutes_d_preset;
        r_mu      <= w_ld_mu;
        r_sd      <= w_ld_sd;
        r_su      <= 4'd0;
        r_presc   <= '0;
        r_tick    <= 1'b0;
        r_expired <= 1'b0;
      end else if (w_go) begin
        if (w_wrap) begin
          r_presc   <= '0;
          r_md      <= w_md_dec;
          r_mu      <= w_mu_dec;
          r_sd      <= w_sd_dec;
          r_su      <= w_su_dec;
          r_tick    <= 1'b1;
          r_expired <= w_dec_zero;
        end else begin
          r_presc   <= r_presc + PW'(1);
          r_tick    <= 1'b0;
          r_expired <= 1'b0;
        end
      end else begin
        r_presc   <= w_zero ? '0 : r_presc;
        r_tick    <= 1'b0;
        r_expired <= 1'b0;
      end
    end
  end

  assign minutes_d   = r_md;
  assign minutes_u   = r_mu;
  assign seconds_d   = r_sd;
  assign seconds_u   = r_su;
  assign second_tick = r_tick;
  assign expired     = r_expired;
  assign active      = r_active;

endmodule
